// File: rtl/mos6502_lite.sv
// Reduced NMOS 6502 core: reset sequence, vector fetch, and NOP/LDA#/JMP/STA zp.
// Bus outputs are registered; db is sampled on the rising edge that ends a cycle.
module mos6502_lite (
    input  logic clk0,
    input  logic res,
    input  logic rdy,
    input  logic irq,
    input  logic nmi,
    input  logic so,
    input  logic clk1out,
    input  logic clk2out,
    input  logic vcc,
    input  logic vss,
    output logic ab0,
    output logic ab1,
    output logic ab2,
    output logic ab3,
    output logic ab4,
    output logic ab5,
    output logic ab6,
    output logic ab7,
    output logic ab8,
    output logic ab9,
    output logic ab10,
    output logic ab11,
    output logic ab12,
    output logic ab13,
    output logic ab14,
    output logic ab15,
    inout  wire  db0,
    inout  wire  db1,
    inout  wire  db2,
    inout  wire  db3,
    inout  wire  db4,
    inout  wire  db5,
    inout  wire  db6,
    inout  wire  db7,
    output logic rw,
    output logic sync
);

    typedef enum logic [3:0] {
        R0, R1, R2, R3, R4, R5, R6, T0, T1, T2
    } state_t;

    state_t      t_q, t_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ab_q, ab_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  s_q, s_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  dl_q, dl_d;
    logic [7:0]  dout_q, dout_d;
    logic        n_q, n_d;
    logic        z_q, z_d;
    logic        rw_q, rw_d;
    logic        sync_q, sync_d;

    logic [7:0]  din;
    logic [7:0]  s_dec;
    logic [15:0] pc_inc;
    logic        stall;
    logic        unused_pins;

    assign din    = {db7, db6, db5, db4, db3, db2, db1, db0};
    assign s_dec  = s_q - 8'd1;
    assign pc_inc = pc_q + 16'd1;
    assign stall  = rw_q && !rdy;

    // Interrupt, phase and supply pins have no function in this core.
    assign unused_pins = ^{irq, nmi, so, clk1out, clk2out, vcc, vss, n_q, z_q};

    always_comb begin
        t_d    = t_q;
        pc_d   = pc_q;
        ab_d   = ab_q;
        a_d    = a_q;
        s_d    = s_q;
        ir_d   = ir_q;
        dl_d   = dl_q;
        dout_d = dout_q;
        n_d    = n_q;
        z_d    = z_q;
        rw_d   = rw_q;
        sync_d = sync_q;
        if (!stall) begin
            rw_d   = 1'b1;
            sync_d = 1'b0;
            unique case (t_q)
                R0: begin
                    t_d  = R1;
                    ab_d = pc_q;
                end
                R1, R2, R3: begin
                    t_d  = (t_q == R1) ? R2 : (t_q == R2) ? R3 : R4;
                    s_d  = s_dec;
                    ab_d = {8'h01, s_dec};
                end
                R4: begin
                    t_d  = R5;
                    ab_d = 16'hFFFC;
                end
                R5: begin
                    t_d       = R6;
                    pc_d[7:0] = din;
                    ab_d      = 16'hFFFD;
                end
                R6: begin
                    t_d        = T0;
                    pc_d[15:8] = din;
                    ab_d       = {din, pc_q[7:0]};
                    sync_d     = 1'b1;
                end
                T0: begin
                    t_d  = T1;
                    ir_d = din;
                    pc_d = pc_inc;
                    ab_d = pc_inc;
                end
                T1: begin
                    unique case (ir_q)
                        8'hA9: begin
                            t_d    = T0;
                            a_d    = din;
                            n_d    = din[7];
                            z_d    = (din == 8'h00);
                            pc_d   = pc_inc;
                            ab_d   = pc_inc;
                            sync_d = 1'b1;
                        end
                        8'h4C: begin
                            t_d  = T2;
                            dl_d = din;
                            pc_d = pc_inc;
                            ab_d = pc_inc;
                        end
                        8'h85: begin
                            t_d    = T2;
                            pc_d   = pc_inc;
                            ab_d   = {8'h00, din};
                            rw_d   = 1'b0;
                            dout_d = a_q;
                        end
                        default: begin
                            t_d    = T0;
                            ab_d   = pc_q;
                            sync_d = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    t_d    = T0;
                    sync_d = 1'b1;
                    if (ir_q == 8'h4C) begin
                        pc_d = {din, dl_q};
                        ab_d = {din, dl_q};
                    end else begin
                        ab_d = pc_q;
                    end
                end
                default: begin
                    t_d  = R0;
                    ab_d = 16'h0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk0 or negedge res) begin
        if (!res) begin
            t_q    <= R0;
            pc_q   <= 16'h0000;
            ab_q   <= 16'h0000;
            a_q    <= 8'h00;
            s_q    <= 8'h00;
            ir_q   <= 8'h00;
            dl_q   <= 8'h00;
            dout_q <= 8'h00;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            rw_q   <= 1'b1;
            sync_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            pc_q   <= pc_d;
            ab_q   <= ab_d;
            a_q    <= a_d;
            s_q    <= s_d;
            ir_q   <= ir_d;
            dl_q   <= dl_d;
            dout_q <= dout_d;
            n_q    <= n_d;
            z_q    <= z_d;
            rw_q   <= rw_d;
            sync_q <= sync_d;
        end
    end

    assign {ab15, ab14, ab13, ab12, ab11, ab10, ab9, ab8,
            ab7, ab6, ab5, ab4, ab3, ab2, ab1, ab0} = ab_q;

    // Data bus is driven only in write cycles and releases with rw.
    assign db0 = rw_q ? 1'bz : dout_q[0];
    assign db1 = rw_q ? 1'bz : dout_q[1];
    assign db2 = rw_q ? 1'bz : dout_q[2];
    assign db3 = rw_q ? 1'bz : dout_q[3];
    assign db4 = rw_q ? 1'bz : dout_q[4];
    assign db5 = rw_q ? 1'bz : dout_q[5];
    assign db6 = rw_q ? 1'bz : dout_q[6];
    assign db7 = rw_q ? 1'bz : dout_q[7];

    assign rw   = rw_q;
    assign sync = sync_q;

endmodule

// File: tb/tb_mos6502_lite.sv
// Directed bench for mos6502_lite with a 64K memory model on the pin bus.
// Samples 1 time unit after each rising clk0 edge.
module tb_mos6502_lite;

    logic clk0, res, rdy;
    logic irq, nmi, so, clk1out, clk2out, vcc, vss;
    wire  [15:0] ab;
    wire  rw, sync;
    wire  d0, d1, d2, d3, d4, d5, d6, d7;
    wire  [7:0] db;

    logic [7:0]  mem [0:65535];
    logic        const_ea;
    logic [7:0]  rdata;
    int          checks, errors;
    int          wr_cnt;
    logic [15:0] wa;
    logic [7:0]  wd;

    mos6502_lite dut (
        .clk0(clk0), .res(res), .rdy(rdy), .irq(irq), .nmi(nmi),
        .so(so), .clk1out(clk1out), .clk2out(clk2out),
        .vcc(vcc), .vss(vss),
        .ab0(ab[0]), .ab1(ab[1]), .ab2(ab[2]), .ab3(ab[3]),
        .ab4(ab[4]), .ab5(ab[5]), .ab6(ab[6]), .ab7(ab[7]),
        .ab8(ab[8]), .ab9(ab[9]), .ab10(ab[10]), .ab11(ab[11]),
        .ab12(ab[12]), .ab13(ab[13]), .ab14(ab[14]), .ab15(ab[15]),
        .db0(d0), .db1(d1), .db2(d2), .db3(d3),
        .db4(d4), .db5(d5), .db6(d6), .db7(d7),
        .rw(rw), .sync(sync)
    );

    assign rdata = const_ea ? 8'hEA : mem[ab];
    assign d0 = rw ? rdata[0] : 1'bz;
    assign d1 = rw ? rdata[1] : 1'bz;
    assign d2 = rw ? rdata[2] : 1'bz;
    assign d3 = rw ? rdata[3] : 1'bz;
    assign d4 = rw ? rdata[4] : 1'bz;
    assign d5 = rw ? rdata[5] : 1'bz;
    assign d6 = rw ? rdata[6] : 1'bz;
    assign d7 = rw ? rdata[7] : 1'bz;
    assign db = {d7, d6, d5, d4, d3, d2, d1, d0};

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    always @(posedge clk0) begin
        if (res && !rw) begin
            wr_cnt <= wr_cnt + 1;
            wa     <= ab;
            wd     <= db;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk0);
        #1;
    endtask

    task automatic bus(input string tag, input logic [15:0] a,
                       input logic r, input logic s);
        chk(tag, {ab, rw, sync}, {a, r, s});
    endtask

    // Called just after res rises; ends at the first opcode fetch.
    task automatic reset_seq(input logic [15:0] fetch);
        logic [15:0] exp [0:6];
        exp = '{16'h0000, 16'h0000, 16'h01FF, 16'h01FE,
                16'h01FD, 16'hFFFC, 16'hFFFD};
        bus("rst_r0", exp[0], 1'b1, 1'b0);
        for (int i = 1; i < 7; i++) begin
            cyc();
            bus($sformatf("rst_r%0d", i), exp[i], 1'b1, 1'b0);
        end
        cyc();
        bus("rst_fetch", fetch, 1'b1, 1'b1);
        chk("rst_s", {24'h0, dut.s_q}, 32'h0000_00FD);
    endtask

    task automatic prog_trace(input string tag, input logic [7:0] imm);
        logic [15:0] ea [0:8];
        logic        er [0:8];
        logic        es [0:8];
        ea = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0010,
               16'h0204, 16'h0205, 16'h0206, 16'h0200};
        er = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        es = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            bus($sformatf("%s_c%0d", tag, i), ea[i], er[i], es[i]);
            if (i == 4) chk({tag, "_wdata"}, {24'h0, db}, {24'h0, imm});
            if (i < 8) cyc();
        end
    endtask

    initial begin
        checks = 0; errors = 0; wr_cnt = 0; wa = '0; wd = '0;
        res = 1'b0; rdy = 1'b1; const_ea = 1'b1;
        irq = 1'b1; nmi = 1'b1; so = 1'b1;
        clk1out = 1'b0; clk2out = 1'b0; vcc = 1'b1; vss = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h02;
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h00;
        mem[16'h0202] = 8'h85; mem[16'h0203] = 8'h10;
        mem[16'h0204] = 8'h4C; mem[16'h0205] = 8'h00;
        mem[16'h0206] = 8'h02;
        mem[16'h0010] = 8'h55;
        mem[16'h0000] = 8'h3C;

        #1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            bus("hold_reset", 16'h0000, 1'b1, 1'b0);
        end

        res = 1'b1;
        reset_seq(16'hEAEA);

        cyc(); bus("nop_t1_a", 16'hEAEB, 1'b1, 1'b0);
        cyc(); bus("nop_t0_b", 16'hEAEB, 1'b1, 1'b1);
        cyc(); bus("nop_t1_b", 16'hEAEC, 1'b1, 1'b0);
        cyc(); bus("nop_t0_c", 16'hEAEC, 1'b1, 1'b1);

        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus($sformatf("rdy_hold%0d", i), 16'hEAEC, 1'b1, 1'b1);
        end
        rdy = 1'b1;
        cyc(); bus("rdy_resume1", 16'hEAED, 1'b1, 1'b0);
        cyc(); bus("rdy_resume2", 16'hEAED, 1'b1, 1'b1);
        cyc(); bus("rdy_resume3", 16'hEAEE, 1'b1, 1'b0);

        res = 1'b0; const_ea = 1'b0;
        #1;
        bus("async_rst", 16'h0000, 1'b1, 1'b0);
        cyc(); cyc();
        res = 1'b1;
        reset_seq(16'h0200);

        prog_trace("prog0", 8'h00);
        chk("wr_cnt0", wr_cnt, 1);
        chk("wr_addr0", {16'h0, wa}, 32'h0000_0010);
        chk("wr_data0", {24'h0, wd}, 32'h0000_0000);
        chk("a_0", {24'h0, dut.a_q}, 32'h0000_0000);
        chk("nz_0", {30'h0, dut.n_q, dut.z_q}, 32'h1);

        mem[16'h0201] = 8'h80;
        prog_trace("prog1", 8'h80);
        chk("wr_cnt1", wr_cnt, 2);
        chk("wr_data1", {24'h0, wd}, 32'h0000_0080);
        chk("a_1", {24'h0, dut.a_q}, 32'h0000_0080);
        chk("nz_1", {30'h0, dut.n_q, dut.z_q}, 32'h2);

        for (int i = 0; i < 4; i++) cyc();
        bus("sta_t2", 16'h0010, 1'b0, 1'b0);
        res = 1'b0;
        #1;
        bus("abort_bus", 16'h0000, 1'b1, 1'b0);
        chk("abort_db", {24'h0, db}, 32'h0000_003C);
        cyc();
        chk("abort_nowr", wr_cnt, 2);
        res = 1'b1;
        reset_seq(16'h0200);
        prog_trace("prog2", 8'h80);
        chk("wr_cnt2", wr_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
